// File: rtl/gpio_arbiter_if.sv
// gpio_arbiter_if: one requester's access channel into the GPIO arbiter.
//
// Handshake: a requester raises valid with we/sel/data/lock and must hold
// those fields stable while valid=1 and ready=0. The access is accepted on the
// rising edge where valid && ready are both 1. Dropping valid before that edge
// withdraws the request. resp_valid pulses for exactly one cycle per accepted
// access. resp_data carries the read data (0 for writes) and holds its value
// until the next response on this channel.
//
// Signals:
//   valid      requester -> arbiter  access pending
//   we         requester -> arbiter  1 = write, 0 = read
//   sel        requester -> arbiter  GPIO register select
//   data       requester -> arbiter  write data
//   lock       requester -> arbiter  keep the grant after this access
//   ready      arbiter -> requester  accepted this cycle (combinational)
//   resp_valid arbiter -> requester  one-cycle response pulse
//   resp_data  arbiter -> requester  read data, 0 for writes
interface gpio_arbiter_if;
    logic        valid;
    logic        we;
    logic [2:0]  sel;
    logic [31:0] data;
    logic        lock;
    logic        ready;
    logic        resp_valid;
    logic [31:0] resp_data;

    modport master (
        output valid, we, sel, data, lock,
        input  ready, resp_valid, resp_data
    );

    modport slave (
        input  valid, we, sel, data, lock,
        output ready, resp_valid, resp_data
    );
endinterface

// File: rtl/gpio_arbiter.sv
// gpio_arbiter: shares the gpio register port (reg_sel/we/di/rd_data) between
// two requesters with round-robin arbitration, an optional bus lock for atomic
// sequences, and a watchdog that drops a lock the owner stops using.
// Every accepted access runs IDLE -> ACCESS -> RESP -> IDLE.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   req0         requester 0 channel (CPU bus)
//   req1         requester 1 channel (pattern/DMA engine)
//   reg_sel      to gpio register select
//   we           to gpio write enable (high only during ACCESS of a write)
//   di           to gpio write data
//   rd_data      from gpio read data (combinational function of reg_sel)
//   grant_owner  requester being served / last served
//   dbg_state    current FSM state for observation
module gpio_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    gpio_arbiter_if.slave      req0,
    gpio_arbiter_if.slave      req1,
    output logic [2:0]         reg_sel,
    output logic               we,
    output logic [31:0]        di,
    input  logic [31:0]        rd_data,
    output logic               grant_owner,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] TMO = 8'(LOCK_TIMEOUT);

    state_t      state, state_next;
    logic        prio;
    logic        lock_active;
    logic        lock_owner;
    logic [7:0]  tmo_cnt;
    logic [31:0] resp_data0, resp_data1;

    logic        elig0, elig1, winner, accept, owner_valid;
    logic        win_we, win_lock;
    logic [2:0]  win_sel;
    logic [31:0] win_data;

    // Arbitration: a held lock makes only its owner eligible; with two
    // eligible requesters prio decides. Requests are ignored during reset.
    always_comb begin
        elig0       = req0.valid && (!lock_active || !lock_owner);
        elig1       = req1.valid && (!lock_active ||  lock_owner);
        winner      = (elig0 && elig1) ? prio : elig1;
        accept      = (state == IDLE) && !reset && (elig0 || elig1);
        win_we      = winner ? req1.we   : req0.we;
        win_sel     = winner ? req1.sel  : req0.sel;
        win_data    = winner ? req1.data : req0.data;
        win_lock    = winner ? req1.lock : req0.lock;
        owner_valid = lock_owner ? req1.valid : req0.valid;
    end

    assign req0.ready      = accept && !winner;
    assign req1.ready      = accept &&  winner;
    assign req0.resp_valid = (state == RESP) && !grant_owner;
    assign req1.resp_valid = (state == RESP) &&  grant_owner;
    assign req0.resp_data  = resp_data0;
    assign req1.resp_data  = resp_data1;
    assign dbg_state       = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_sel     <= 3'd0;
            we          <= 1'b0;
            di          <= 32'd0;
            grant_owner <= 1'b0;
            prio        <= 1'b0;
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
            tmo_cnt     <= 8'd0;
            resp_data0  <= 32'd0;
            resp_data1  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        reg_sel     <= win_sel;
                        di          <= win_data;
                        we          <= win_we;
                        grant_owner <= winner;
                        prio        <= ~winner;
                        lock_active <= win_lock;
                        lock_owner  <= winner;
                        tmo_cnt     <= 8'd0;
                    end else if (lock_active && !owner_valid) begin
                        // The count about to reach LOCK_TIMEOUT releases the
                        // lock instead, so the counter can never pass it.
                        if (tmo_cnt >= TMO - 8'd1) begin
                            lock_active <= 1'b0;
                            tmo_cnt     <= 8'd0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                    end
                end
                ACCESS: begin
                    // we is still high here for writes; it selects the zero
                    // response and is then dropped after its single cycle.
                    we <= 1'b0;
                    if (grant_owner) resp_data1 <= we ? 32'd0 : rd_data;
                    else             resp_data0 <= we ? 32'd0 : rd_data;
                end
                default: ;
            endcase
        end
    end

endmodule
